// File: rtl/comparator_serial.sv
// Bit-serial MSB-first unsigned magnitude comparator with registered one-hot eq/lt/gt result.
// Define COMPARATOR_SERIAL_EARLY_EXIT_EN to finish on the first differing bit-pair.
module comparator_serial #(
    parameter int unsigned WIDTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic a_bit,
    input  logic b_bit,
    input  logic bit_valid,
    output logic bit_ready,
    output logic busy,
    output logic done,
    output logic eq,
    output logic lt,
    output logic gt
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            decided_q, decided_d;
    logic            a_gt_q, a_gt_d;
    logic            eq_q, eq_d;
    logic            lt_q, lt_d;
    logic            gt_q, gt_d;
    logic            beat;
    logic            differ;
    logic            last;

    assign beat   = bit_valid && (state_q == StShift);
    assign differ = !decided_q && (a_bit != b_bit);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        decided_d = decided_q;
        a_gt_d    = a_gt_q;
        eq_d      = eq_q;
        lt_d      = lt_q;
        gt_d      = gt_q;
        last      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StShift;
                    cnt_d     = '0;
                    decided_d = 1'b0;
                    a_gt_d    = 1'b0;
                end
            end
            StShift: begin
                if (beat) begin
                    if (differ) begin
                        decided_d = 1'b1;
                        a_gt_d    = a_bit;
                    end
`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
                    last = (cnt_q == LastCnt) || differ;
`else
                    last = (cnt_q == LastCnt);
`endif
                    // Counter stops at the last beat so it never wraps.
                    if (last) begin
                        state_d = StDone;
                        eq_d    = !decided_d;
                        gt_d    = decided_d && a_gt_d;
                        lt_d    = decided_d && !a_gt_d;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            decided_q <= 1'b0;
            a_gt_q    <= 1'b0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
            gt_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            decided_q <= decided_d;
            a_gt_q    <= a_gt_d;
            eq_q      <= eq_d;
            lt_q      <= lt_d;
            gt_q      <= gt_d;
        end
    end

    assign bit_ready = (state_q == StShift);
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign eq        = eq_q;
    assign lt        = lt_q;
    assign gt        = gt_q;

endmodule

// File: tb/tb_comparator_serial.sv
// Scoreboard bench for comparator_serial (WIDTH=4): stimulus pushes expected flags,
// a negedge monitor pops and checks them on every done pulse.
module tb_comparator_serial;

    localparam int unsigned WIDTH = 4;
`ifdef COMPARATOR_SERIAL_EARLY_EXIT_EN
    localparam bit Early = 1'b1;
`else
    localparam bit Early = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic a_bit = 1'b0;
    logic b_bit = 1'b0;
    logic bit_valid = 1'b0;
    logic bit_ready, busy, done, eq, lt, gt;

    int total = 0;
    int bad = 0;
    longint cyc = 0;
    logic [2:0] exp_q[$];           // {eq, lt, gt}
    logic [2:0] prev = 3'b000;      // flags expected to be held during an operation

    comparator_serial #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .busy      (busy),
        .done      (done),
        .eq        (eq),
        .lt        (lt),
        .gt        (gt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [2:0] w;
                w = exp_q.pop_front();
                chk("result_flags", {29'd0, eq, lt, gt}, {29'd0, w});
            end
        end
    end

    function automatic int exp_beats(input logic [3:0] a, input logic [3:0] b);
        if (Early) begin
            for (int k = 0; k < 4; k++)
                if (a[3-k] != b[3-k]) return k + 1;
        end
        return WIDTH;
    endfunction

    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input int bub_at,
                         input int nbub, input bit start_mid, input bit start_in_done,
                         output longint scyc);
        logic [2:0] w;
        int eb, beats, cycles, i, left;
        bit got;
        w = {a == b, a < b, a > b};
        exp_q.push_back(w);
        eb = exp_beats(a, b);
        start = 1'b1;
        @(posedge clk);
        scyc = cyc;
        #1 start = 1'b0;
        beats = 0; cycles = 0; i = 0; got = 1'b0; left = nbub;
        while (!got && cycles < 20) begin
            if (i == bub_at && left > 0) begin
                bit_valid = 1'b0;
                left--;
            end else begin
                bit_valid = 1'b1;
                a_bit = (i < 4) ? a[3-i] : 1'b0;
                b_bit = (i < 4) ? b[3-i] : 1'b0;
                chk("ready_in_shift", {31'd0, bit_ready}, 32'd1);
                chk("flags_held", {29'd0, eq, lt, gt}, {29'd0, prev});
                if (start_mid && i == 1) start = 1'b1;
            end
            @(posedge clk);
            #1 start = 1'b0;
            cycles++;
            if (bit_valid) begin
                beats++;
                i++;
            end
            if (done) got = 1'b1;
        end
        bit_valid = 1'b0;
        chk("done_seen", {31'd0, got}, 32'd1);
        chk("beats_consumed", beats, eb);
        chk("done_latency", cycles, eb + nbub);
        chk("ready_low_in_done", {31'd0, bit_ready}, 32'd0);
        chk("busy_in_done", {31'd0, busy}, 32'd1);
        if (start_in_done) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        prev = w;
    endtask

    initial begin
        longint s0, s1;
        #3;
        chk("reset_outputs", {26'd0, bit_ready, busy, done, eq, lt, gt}, 32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_outputs", {26'd0, bit_ready, busy, done, eq, lt, gt}, 32'd0);

        do_op(4'b0000, 4'b0001, -1, 0, 1'b0, 1'b0, s0);   // lt
        do_op(4'b1000, 4'b0111, -1, 0, 1'b0, 1'b0, s0);   // gt
        do_op(4'b1111, 4'b1111, 2, 2, 1'b0, 1'b0, s0);    // eq with two bubbles
        do_op(4'b0101, 4'b1010, -1, 0, 1'b1, 1'b1, s0);   // lt, stray starts ignored

        // Asynchronous reset after two beats of 1100 vs 0011.
        if (Early) exp_q.push_back(3'b001);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bit_valid = 1'b1;
            a_bit = k[0] ? 1'b1 : 1'b1;
            b_bit = 1'b0;
            @(posedge clk);
            #1;
        end
        bit_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset", {26'd0, bit_ready, busy, done, eq, lt, gt}, 32'd0);
        #1 rst_n = 1'b1;
        prev = 3'b000;
        @(posedge clk);
        #1;
        do_op(4'b0011, 4'b0011, -1, 0, 1'b0, 1'b0, s0);   // eq, no stale gt

        // Back-to-back: second start in the first IDLE cycle.
        do_op(4'b0110, 4'b0101, -1, 0, 1'b0, 1'b0, s0);   // gt
        do_op(4'b0010, 4'b0100, -1, 0, 1'b0, 1'b0, s1);   // lt
        chk("min_period", 32'(s1 - s0), 32'(exp_beats(4'b0110, 4'b0101) + 2));

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/comparator_serial.md
Name: comparator_serial

Overview:
Bit-serial magnitude comparator for two unsigned WIDTH-bit operands.
- The operands arrive MSB-first, one bit-pair per accepted beat, from an upstream serializer over a valid/ready handshake.
- After the last beat the block produces registered one-hot eq/lt/gt flags and a one-cycle done pulse.
- It is the sequential, serial-link counterpart of the team's parallel 4-bit comparator and sits at the receiving end of a serialized operand stream.

Parameters:
WIDTH, 4, operand width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a new comparison; honoured only in IDLE
a_bit  input  1  current bit of operand A (MSB first)
b_bit  input  1  current bit of operand B (MSB first)
bit_valid  input  1  a_bit/b_bit valid this cycle
bit_ready  output  1  block accepts a bit-pair this cycle
busy  output  1  high in SHIFT and DONE
done  output  1  one-cycle pulse; result flags updated this cycle
eq  output  1  A == B (registered)
lt  output  1  A < B (registered)
gt  output  1  A > B (registered)

Behaviour:
- Reset (asynchronous, any state including mid-operation):
  - state = IDLE; beat counter = 0; decided = 0.
  - bit_ready = 0, busy = 0, done = 0, eq = 0, lt = 0, gt = 0.
  - No partial result survives reset.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - bit_ready = 0.
  - If start = 1 at a clock edge: go to SHIFT; clear the counter, decided and a_gt.
- SHIFT:
  - bit_ready = 1 combinationally (function of state only, never of bit_valid).
  - A beat is accepted when bit_valid && bit_ready at a clock edge. bit_valid low inserts bubbles with no state change.
  - On each beat: if decided = 0 and a_bit != b_bit, set decided = 1 and a_gt = a_bit. Increment the counter.
  - When the beat with counter == WIDTH-1 is accepted: go to DONE and register the result:
    - eq = !decided_next
    - gt = decided_next && a_gt_next
    - lt = decided_next && !a_gt_next
- DONE:
  - done = 1 for exactly one cycle; bit_ready = 0; then return to IDLE.
- Latency:
  - start is sampled at edge 0; the first beat can be accepted at edge 1.
  - With no bubbles, done is high in the cycle after edge WIDTH.
  - Minimum start-to-start period is WIDTH+2 cycles.
- Result hold: eq/lt/gt keep the previous result through IDLE and SHIFT. They change only at the edge that enters DONE.
- One-hot: after the first done, exactly one of eq/lt/gt is high.
- start while busy (SHIFT or DONE) is ignored, including start asserted in the DONE cycle. A new start is accepted only in IDLE.
- bit_valid while not in SHIFT is ignored; a_bit/b_bit are don't-care.
- Counter width is $clog2(WIDTH); it never wraps within one operation.

Optional Feature:
Macro: COMPARATOR_SERIAL_EARLY_EXIT_EN
- Defined:
  - The first accepted beat with a_bit != b_bit ends the operation: go to DONE with the result registered from that beat.
  - Remaining bits are not consumed, and bit_ready drops in the next cycle.
  - The upstream serializer must discard its remaining bits on done.
  - Equal operands still take WIDTH beats.
- Undefined:
  - Exactly WIDTH beats are always consumed, as described above.

Test Plan:
1. WIDTH=4, A=0000, B=0001, no bubbles -> done in the cycle after edge 4; eq=0, lt=1, gt=0.
2. A=1000, B=0111 -> gt=1, lt=0, eq=0. With EARLY_EXIT_EN: done follows the first beat, and only 1 beat is consumed. Without it: 4 beats are consumed.
3. A=1111, B=1111 with bit_valid low for 2 cycles between beats 1 and 2 -> eq=1; done is delayed by exactly 2 cycles; flags hold the previous result until done.
4. A=0101, B=1010; start pulsed again during SHIFT and in the DONE cycle -> lt=1; both extra starts are ignored; busy falls in the cycle after done.
5. rst_n pulsed low after 2 beats of A=1100, B=0011 -> all outputs 0 immediately (asynchronously). A following start with A=0011, B=0011 gives eq=1 and no stale gt.
6. Back-to-back: start asserted in the first IDLE cycle after done -> the second operation begins; the minimum period of WIDTH+2 cycles is met.
